// File: rtl/mem_pkg.sv
// Shared types, default sizes and the byte-parity helper for the parametrised RAM.
package mem_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_DEPTH      = 64;
  localparam int unsigned DEF_ADDR_WIDTH = 6;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Even parity: the stored bit makes the byte plus parity carry an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Post-reset clear sequencer: walks every word once, then parks in READY.
module mem_clear_seq
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  busy,
  output logic                  clrWe,
  output logic [ADDR_WIDTH-1:0] clrAddr
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  busy_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= (state_d == CLEAR);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // busy_q mirrors state_q == CLEAR, so it doubles as the clear write strobe.
  assign busy    = busy_q;
  assign clrWe   = busy_q;
  assign clrAddr = ptr_q;

endmodule

// File: rtl/memory_module_param.sv
// Parametrised single-port RAM with byte enables, registered read and post-reset clear.
// Optional per-byte even parity and parityErr output when MEM_PARITY_EN is defined.
module memory_module_param
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    rE,
  input  logic                    wE,
  input  logic [DATA_WIDTH/8-1:0] byteEn,
  output logic [DATA_WIDTH-1:0]   dataOut,
  output logic                    dataValid,
`ifdef MEM_PARITY_EN
  output logic                    parityErr,
`endif
  output logic                    busy
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  logic                  clrWe;
  logic [ADDR_WIDTH-1:0] clrAddr;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  in_range_c;
  logic                  wr_en_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [NB-1:0]         wr_mask_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [DATA_WIDTH-1:0] wr_word_c;
  logic                  rd_fire_c;
  logic [DATA_WIDTH-1:0] rd_data_c;

  logic [DATA_WIDTH-1:0] dataOut_q;
  logic                  dataValid_q;

  mem_clear_seq #(
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_seq (
    .clock  (clock),
    .reset  (reset),
    .busy   (busy),
    .clrWe  (clrWe),
    .clrAddr(clrAddr)
  );

  assign in_range_c = (32'(address) < DEPTH);
  assign rd_fire_c  = rE & ~clrWe;
  assign rd_data_c  = in_range_c ? mem_q[address] : '0;

  // Clear sequencer owns the write port while it runs.
  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = address;
    wr_mask_c = byteEn;
    wr_data_c = data;
    if (clrWe) begin
      wr_en_c   = 1'b1;
      wr_addr_c = clrAddr;
      wr_mask_c = '1;
      wr_data_c = '0;
    end else if (wE && in_range_c) begin
      wr_en_c = 1'b1;
    end
  end

  always_comb begin
    wr_word_c = mem_q[wr_addr_c];
    for (int i = 0; i < NB; i++) begin
      if (wr_mask_c[i]) wr_word_c[8*i +: 8] = wr_data_c[8*i +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en_c) mem_q[wr_addr_c] <= wr_word_c;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dataOut_q   <= '0;
      dataValid_q <= 1'b0;
    end else begin
      dataValid_q <= rd_fire_c;
      if (rd_fire_c) dataOut_q <= rd_data_c;
    end
  end

  assign dataOut   = dataOut_q;
  assign dataValid = dataValid_q;

`ifdef MEM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] wr_par_c;
  logic          rd_perr_c;
  logic          parityErr_q;

  always_comb begin
    wr_par_c  = par_q[wr_addr_c];
    rd_perr_c = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (wr_mask_c[i]) wr_par_c[i] = byte_parity(wr_data_c[8*i +: 8]);
      if (in_range_c && (byte_parity(mem_q[address][8*i +: 8]) != par_q[address][i]))
        rd_perr_c = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en_c) par_q[wr_addr_c] <= wr_par_c;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      parityErr_q <= 1'b0;
    end else if (rd_fire_c) begin
      parityErr_q <= rd_perr_c;
    end
  end

  assign parityErr = parityErr_q;
`endif

endmodule

// File: tb/tb_memory_module_param.sv
// Self-checking bench: a 64-word and a 48-word instance driven by shared stimulus.
module tb_memory_module_param;

  typedef struct {
    logic        r;
    logic        w;
    logic [5:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        ev;
    logic [31:0] ed0;
    logic [31:0] ed1;
  } vec_t;

  typedef struct {
    logic        ev;
    logic [31:0] ed0;
    logic [31:0] ed1;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data = '0;
  logic [5:0]  address = '0;
  logic        rE = 1'b0;
  logic        wE = 1'b0;
  logic [3:0]  byteEn = '0;
  logic [31:0] dout0, dout1;
  logic        dv0, dv1, busy0, busy1;
`ifdef MEM_PARITY_EN
  logic        perr0, perr1;
`endif

  exp_t sb_q[$];
  vec_t tbl[20];
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  memory_module_param #(.DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(6)) u0 (
    .clock(clock), .reset(reset), .data(data), .address(address), .rE(rE), .wE(wE),
    .byteEn(byteEn), .dataOut(dout0), .dataValid(dv0),
`ifdef MEM_PARITY_EN
    .parityErr(perr0),
`endif
    .busy(busy0)
  );

  memory_module_param #(.DATA_WIDTH(32), .DEPTH(48), .ADDR_WIDTH(6)) u1 (
    .clock(clock), .reset(reset), .data(data), .address(address), .rE(rE), .wE(wE),
    .byteEn(byteEn), .dataOut(dout1), .dataValid(dv1),
`ifdef MEM_PARITY_EN
    .parityErr(perr1),
`endif
    .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus at a negedge; result is compared at the following negedge.
  task automatic step(input logic r, input logic w, input logic [5:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic ev, input logic [31:0] e0,
                      input logic [31:0] e1);
    exp_t e;
    e.ev = ev; e.ed0 = e0; e.ed1 = e1;
    sb_q.push_back(e);
    rE = r; wE = w; address = a; data = d; byteEn = be;
    @(posedge clock);
    @(negedge clock);
    rE = 1'b0; wE = 1'b0;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("dv0@%0d", a), 32'(dv0), 32'(e.ev));
      check($sformatf("dout0@%0d", a), dout0, e.ed0);
      check($sformatf("dv1@%0d", a), 32'(dv1), 32'(e.ev));
      check($sformatf("dout1@%0d", a), dout1, e.ed1);
    end
  endtask

  // Counts busy cycles of both instances from the current negedge; pokes rE/wE while busy.
  task automatic count_clear(output int c0, output int c1, output int dvhit);
    c0 = 0; c1 = 0; dvhit = 0;
    address = 6'd1; data = 32'hFFFF_FFFF; byteEn = 4'hF;
    for (int k = 0; k < 200; k++) begin
      if (busy0) c0++;
      if (busy1) c1++;
      if (dv0 || dv1) dvhit++;
      rE = busy1; wE = busy1;
      if (!busy0 && !busy1) break;
      @(negedge clock);
    end
    rE = 1'b0; wE = 1'b0;
  endtask

  initial begin
    int c0, c1, dvh;

    tbl[0]  = '{1'b0, 1'b1, 6'd5,  32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,         32'h0};
    tbl[1]  = '{1'b0, 1'b1, 6'd5,  32'h0000_00AA, 4'h1, 1'b0, 32'h0,         32'h0};
    tbl[2]  = '{1'b1, 1'b0, 6'd5,  32'h0,         4'h0, 1'b1, 32'hDEAD_BEAA, 32'hDEAD_BEAA};
    tbl[3]  = '{1'b0, 1'b0, 6'd5,  32'h0,         4'h0, 1'b0, 32'hDEAD_BEAA, 32'hDEAD_BEAA};
    tbl[4]  = '{1'b0, 1'b1, 6'd3,  32'h1111_1111, 4'hF, 1'b0, 32'hDEAD_BEAA, 32'hDEAD_BEAA};
    tbl[5]  = '{1'b1, 1'b1, 6'd3,  32'h2222_2222, 4'hF, 1'b1, 32'h1111_1111, 32'h1111_1111};
    tbl[6]  = '{1'b1, 1'b0, 6'd3,  32'h0,         4'h0, 1'b1, 32'h2222_2222, 32'h2222_2222};
    tbl[7]  = '{1'b0, 1'b1, 6'd50, 32'h0000_0005, 4'hF, 1'b0, 32'h2222_2222, 32'h2222_2222};
    tbl[8]  = '{1'b1, 1'b0, 6'd50, 32'h0,         4'h0, 1'b1, 32'h0000_0005, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 6'd2,  32'h0,         4'h0, 1'b1, 32'h0,         32'h0};
    tbl[10] = '{1'b0, 1'b1, 6'd7,  32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0,         32'h0};
    tbl[11] = '{1'b1, 1'b0, 6'd7,  32'h0,         4'h0, 1'b1, 32'h0,         32'h0};
    tbl[12] = '{1'b0, 1'b1, 6'd7,  32'h1234_5678, 4'hA, 1'b0, 32'h0,         32'h0};
    tbl[13] = '{1'b1, 1'b0, 6'd7,  32'h0,         4'h0, 1'b1, 32'h1200_5600, 32'h1200_5600};
    tbl[14] = '{1'b1, 1'b0, 6'd5,  32'h0,         4'h0, 1'b1, 32'hDEAD_BEAA, 32'hDEAD_BEAA};
    tbl[15] = '{1'b1, 1'b0, 6'd3,  32'h0,         4'h0, 1'b1, 32'h2222_2222, 32'h2222_2222};
    tbl[16] = '{1'b1, 1'b0, 6'd63, 32'h0,         4'h0, 1'b1, 32'h0,         32'h0};
    tbl[17] = '{1'b0, 1'b1, 6'd63, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0,         32'h0};
    tbl[18] = '{1'b1, 1'b0, 6'd63, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D, 32'h0};
    tbl[19] = '{1'b1, 1'b0, 6'd47, 32'h0,         4'h0, 1'b1, 32'h0,         32'h0};

    // Reset state and clear duration.
    repeat (3) @(negedge clock);
    check("rst_dout0", dout0, 32'h0);
    check("rst_dv0", 32'(dv0), 32'h0);
    check("rst_busy0", 32'(busy0), 32'h1);
    check("rst_busy1", 32'(busy1), 32'h1);
    reset = 1'b1;
    count_clear(c0, c1, dvh);
    check("clear_cycles_64", 32'(c0), 32'd64);
    check("clear_cycles_48", 32'(c1), 32'd48);
    check("dv_during_clear", 32'(dvh), 32'd0);

    // Every word reads back zero; back-to-back reads give one result per cycle.
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 6'(i), 32'h0, 4'h0, 1'b1, 32'h0, 32'h0);

    for (int i = 0; i < 20; i++)
      step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].ev, tbl[i].ed0, tbl[i].ed1);

    // Reset during an in-flight read, then again partway through the clear.
    rE = 1'b1; address = 6'd5;
    @(posedge clock);
    #1;
    check("inflight_dv0", 32'(dv0), 32'h1);
    check("inflight_dout0", dout0, 32'hDEAD_BEAA);
    reset = 1'b0; rE = 1'b0;
    #1;
    check("abort_dv0", 32'(dv0), 32'h0);
    check("abort_dout0", dout0, 32'h0);
    check("abort_busy0", 32'(busy0), 32'h1);
    @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("midclear_busy0", 32'(busy0), 32'h1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    count_clear(c0, c1, dvh);
    check("reclear_cycles_64", 32'(c0), 32'd64);
    check("reclear_cycles_48", 32'(c1), 32'd48);
    check("dv_during_reclear", 32'(dvh), 32'd0);
    step(1'b1, 1'b0, 6'd1, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0);
    step(1'b1, 1'b0, 6'd5, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0);
    step(1'b0, 1'b1, 6'd1, 32'h7, 4'hF, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 6'd1, 32'h0, 4'h0, 1'b1, 32'h7, 32'h7);

`ifdef MEM_PARITY_EN
    step(1'b0, 1'b1, 6'd9, 32'h0000_00FF, 4'hF, 1'b0, 32'h7, 32'h7);
    u0.mem_q[9] = u0.mem_q[9] ^ 32'h1;
    step(1'b1, 1'b0, 6'd9, 32'h0, 4'h0, 1'b1, 32'h0000_00FE, 32'h0000_00FF);
    check("perr0_flipped", 32'(perr0), 32'h1);
    check("perr1_clean", 32'(perr1), 32'h0);
    step(1'b1, 1'b0, 6'd1, 32'h0, 4'h0, 1'b1, 32'h7, 32'h7);
    check("perr0_clean", 32'(perr0), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
